// File: rtl/cpu_pkg.sv
// Shared definitions for the sequential ALU: op codes, flag bit positions
// and the controller state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_EOR  = 4'd5;
  localparam logic [3:0] OP_INC  = 4'd6;
  localparam logic [3:0] OP_DEC  = 4'd7;
  localparam logic [3:0] OP_ASL  = 4'd8;
  localparam logic [3:0] OP_LSR  = 4'd9;
  localparam logic [3:0] OP_ROL  = 4'd10;
  localparam logic [3:0] OP_ROR  = 4'd11;
  localparam logic [3:0] OP_CMP  = 4'd12;

  // Bit positions inside the {N,V,Z,C} flags vector.
  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ADJ  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cpu_bcd_digit.sv
// One decimal digit of the BCD adjust chain. For add, cy is a carry; for
// subtract, cy is a borrow. Non-BCD digits go through the same rules with
// no error indication.
module cpu_bcd_digit (
  input  logic       sub,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cy_in,
  output logic [3:0] digit,
  output logic       cy_out
);

  logic [4:0] sum;
  logic [4:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b} + {4'b0, cy_in};
  // b - a - borrow lies in -16..15, so bit 4 is the sign.
  assign diff = {1'b0, b} - {1'b0, a} - {4'b0, cy_in};

  // Digit correction: +6 past 9 on add, +10 when negative on subtract.
  always_comb begin
    digit  = sum[3:0];
    cy_out = 1'b0;
    if (sub) begin
      if (diff[4]) begin
        digit  = diff[3:0] + 4'd10;
        cy_out = 1'b1;
      end else begin
        digit  = diff[3:0];
      end
    end else if (sum > 5'd9) begin
      digit  = sum[3:0] + 4'd6;
      cy_out = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_alu_seq.sv
// Sequential ALU with {N,V,Z,C} flags and optional BCD add/subtract.
// Handshake: an operation is taken on a rising edge where in_valid && in_ready;
// a result is handed over on a rising edge where out_valid && out_ready, and
// result/flags stay stable while out_valid is high and out_ready is low.
module cpu_alu_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit DECIMAL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             dec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [1:0]       dbg_state
);

  localparam int ND = WIDTH / 4;

  state_e           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic             dec_q;
  logic             accept;

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  // Binary arithmetic on the captured operands.
  logic [WIDTH:0] add_full;
  logic [WIDTH:0] sub_full;
  logic [WIDTH:0] cmp_full;
  logic           add_v;
  logic           sub_v;

  assign add_full = {1'b0, b_q} + {1'b0, a_q} + {{WIDTH{1'b0}}, c_q};
  assign sub_full = {1'b0, b_q} + {1'b0, ~a_q} + {{WIDTH{1'b0}}, c_q};
  assign cmp_full = {1'b0, b_q} + {1'b0, ~a_q} + {{WIDTH{1'b0}}, 1'b1};
  assign add_v    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_full[WIDTH-1] != b_q[WIDTH-1]);
  assign sub_v    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_full[WIDTH-1] != b_q[WIDTH-1]);

  logic [WIDTH-1:0] alu_val;
  logic             alu_c;
  logic             alu_v;
  logic             alu_wr;
  logic             alu_n;
  logic             alu_z;

  // Binary op decode: alu_val feeds N/Z; alu_wr is low only for CMP.
  always_comb begin
    alu_val = a_q;
    alu_c   = c_q;
    alu_v   = flags[FLAG_V];
    alu_wr  = 1'b1;
    case (op_q)
      OP_ADD: begin
        alu_val = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = add_v;
      end
      OP_SUB: begin
        alu_val = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = sub_v;
      end
      OP_OR:  alu_val = b_q | a_q;
      OP_AND: alu_val = b_q & a_q;
      OP_EOR: alu_val = b_q ^ a_q;
      OP_INC: alu_val = a_q + {{(WIDTH-1){1'b0}}, 1'b1};
      OP_DEC: alu_val = a_q - {{(WIDTH-1){1'b0}}, 1'b1};
      OP_ASL: begin
        alu_val = {a_q[WIDTH-2:0], 1'b0};
        alu_c   = a_q[WIDTH-1];
      end
      OP_LSR: begin
        alu_val = {1'b0, a_q[WIDTH-1:1]};
        alu_c   = a_q[0];
      end
      OP_ROL: begin
        alu_val = {a_q[WIDTH-2:0], c_q};
        alu_c   = a_q[WIDTH-1];
      end
      OP_ROR: begin
        alu_val = {c_q, a_q[WIDTH-1:1]};
        alu_c   = a_q[0];
      end
      OP_CMP: begin
        alu_val = cmp_full[WIDTH-1:0];
        alu_c   = cmp_full[WIDTH];
        alu_wr  = 1'b0;
      end
      default: alu_val = a_q;
    endcase
  end

  assign alu_n = alu_val[WIDTH-1];
  assign alu_z = (alu_val == '0);

  // BCD adjust chain, least significant digit first.
  logic             is_sub_op;
  logic             is_dec;
  logic [ND:0]      bcd_cy;
  logic [WIDTH-1:0] bcd_res;
  logic             bcd_c;

  assign is_sub_op = (op_q == OP_SUB);
  assign is_dec    = dec_q && ((op_q == OP_ADD) || (op_q == OP_SUB));
  assign bcd_cy[0] = is_sub_op ? ~c_q : c_q;
  assign bcd_c     = is_sub_op ? ~bcd_cy[ND] : bcd_cy[ND];

  for (genvar i = 0; i < ND; i++) begin : g_digit
    cpu_bcd_digit u_digit (
      .sub    (is_sub_op),
      .a      (a_q[4*i +: 4]),
      .b      (b_q[4*i +: 4]),
      .cy_in  (bcd_cy[i]),
      .digit  (bcd_res[4*i +: 4]),
      .cy_out (bcd_cy[i+1])
    );
  end

  // Controller: captures operands, sequences EXEC/ADJ and registers outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      result <= '0;
      flags  <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      dec_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            c_q   <= c_in;
            dec_q <= dec & DECIMAL_EN;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_dec) begin
            // Decimal overflow comes from the binary sum; N/Z/C wait for ADJ.
            flags[FLAG_V] <= alu_v;
            state         <= ST_ADJ;
          end else begin
            if (alu_wr) begin
              result <= alu_val;
            end
            flags[FLAG_N] <= alu_n;
            flags[FLAG_V] <= alu_v;
            flags[FLAG_Z] <= alu_z;
            flags[FLAG_C] <= alu_c;
            state         <= ST_DONE;
          end
        end
        ST_ADJ: begin
          result        <= bcd_res;
          flags[FLAG_N] <= bcd_res[WIDTH-1];
          flags[FLAG_Z] <= (bcd_res == '0);
          flags[FLAG_C] <= bcd_c;
          state         <= ST_DONE;
        end
        ST_DONE: begin
          if (accept) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            c_q   <= c_in;
            dec_q <= dec & DECIMAL_EN;
            state <= ST_EXEC;
          end else if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_alu_seq.sv
// Bench for cpu_alu_seq (WIDTH=8, DECIMAL_EN=1): directed vectors, backpressure,
// reset mid-operation, then randomized traffic against an arithmetic model.
module tb_cpu_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         dec = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W+3:0] exp_q[$];
  int m_res = 0;
  int m_v = 0;
  bit bp_rand = 1'b0;

  cpu_alu_seq #(.WIDTH(W), .DECIMAL_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .dec       (dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: returns {result, N, V, Z, C} from plain integer arithmetic.
  function automatic logic [11:0] model(input int o, input int aa, input int bb,
                                        input int cc, input int dd, input int pres, input int pv);
    int r, cf, vf, val, full, sa, sb, ss, cy, d;
    logic [7:0] rv;
    sa = (aa >= 128) ? aa - 256 : aa;
    sb = (bb >= 128) ? bb - 256 : bb;
    r = aa; cf = cc; vf = pv; full = 0;
    case (o)
      1: begin
        full = bb + aa + cc;
        ss = sb + sa + cc;
        vf = (ss > 127 || ss < -128) ? 1 : 0;
        if (dd != 0) begin
          cy = cc; r = 0;
          for (int i = 0; i < 2; i++) begin
            d = ((aa >> (4*i)) & 15) + ((bb >> (4*i)) & 15) + cy;
            if (d > 9) begin d = d + 6; cy = 1; end else cy = 0;
            r = r | ((d & 15) << (4*i));
          end
          cf = cy;
        end else begin
          r = full & 255; cf = (full > 255) ? 1 : 0;
        end
      end
      2: begin
        full = bb - aa - (1 - cc);
        ss = sb - sa - (1 - cc);
        vf = (ss > 127 || ss < -128) ? 1 : 0;
        if (dd != 0) begin
          cy = 1 - cc; r = 0;
          for (int i = 0; i < 2; i++) begin
            d = ((bb >> (4*i)) & 15) - ((aa >> (4*i)) & 15) - cy;
            if (d < 0) begin d = d + 10; cy = 1; end else cy = 0;
            r = r | ((d & 15) << (4*i));
          end
          cf = 1 - cy;
        end else begin
          r = full & 255; cf = (full >= 0) ? 1 : 0;
        end
      end
      3: r = aa | bb;
      4: r = aa & bb;
      5: r = aa ^ bb;
      6: r = (aa + 1) & 255;
      7: r = (aa + 255) & 255;
      8: begin r = (aa * 2) & 255; cf = aa / 128; end
      9: begin r = aa / 2; cf = aa % 2; end
      10: begin r = ((aa * 2) & 255) + cc; cf = aa / 128; end
      11: begin r = aa / 2 + cc * 128; cf = aa % 2; end
      12: begin full = bb - aa; cf = (full >= 0) ? 1 : 0; r = pres; end
      default: r = aa;
    endcase
    val = (o == 12) ? (full & 255) : r;
    rv = r[7:0];
    return {rv, (val >= 128), (vf != 0), (val == 0), (cf != 0)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Records the model's answer for an accepted op and advances model state.
  task automatic push_exp(input int o, input int aa, input int bb, input int cc, input int dd,
                          input bit fixed, input logic [11:0] fexp);
    logic [11:0] m;
    m = model(o, aa, bb, cc, dd, m_res, m_v);
    m_res = int'(m[11:4]);
    m_v = int'(m[2]);
    exp_q.push_back(fixed ? fexp : m);
  endtask

  // Driver: present an op from a falling edge until it is accepted.
  task automatic send(input int o, input int aa, input int bb, input int cc, input int dd,
                      input bit fixed, input logic [11:0] fexp);
    int n;
    @(negedge clk);
    op = o[3:0]; a = aa[7:0]; b = bb[7:0]; c_in = cc[0]; dec = dd[0];
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=%0b required=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    push_exp(o, aa, bb, cc, dd, fixed, fexp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called just after the accept edge; counts that edge as cycle 1.
  task automatic expect_latency(input int lat, input string name);
    int n;
    n = 1;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid && n < 10);
    chk(name, n, lat);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // Random backpressure
  initial begin
    forever begin
      @(negedge clk);
      if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard: compare every handed-over result.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none", {result, flags});
        end else begin
          e = exp_q.pop_front();
          if ({result, flags} !== e) begin
            errors++;
            $display("FAIL result_flags actual=%0h required=%0h", {result, flags}, e);
          end
        end
      end
    end
  end

  // Main sequence
  initial begin
    logic [11:0] e;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_result", result, 0);
    chk("reset_flags", flags, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-derived expectations
    send(1, 'h01, 'h7F, 0, 0, 1'b1, {8'h80, 4'b1100});
    expect_latency(2, "add_ovf_latency");
    send(1, 'h01, 'h99, 0, 1, 1'b1, {8'h00, 4'b0011});
    expect_latency(3, "dec_add_latency");
    send(2, 'h13, 'h42, 1, 1, 1'b1, {8'h29, 4'b0001});
    expect_latency(3, "dec_sub_latency");
    send(2, 'h50, 'h20, 1, 1, 1'b1, {8'h70, 4'b0000});
    send(11, 'h01, 'h00, 1, 0, 1'b1, {8'h80, 4'b1001});
    expect_latency(2, "ror_latency");
    send(12, 'h10, 'h10, 0, 0, 1'b1, {8'h80, 4'b0011});
    send(14, 'h5A, 'h33, 1, 0, 1'b0, '0);
    send(6, 'hFF, 'h00, 0, 0, 1'b0, '0);
    send(7, 'h00, 'h00, 1, 0, 1'b0, '0);
    send(2, 'h01, 'h80, 1, 0, 1'b0, '0);
    drain("drain_directed");

    // Backpressure then a no-bubble accept
    @(negedge clk);
    out_ready = 1'b0;
    send(1, 'h35, 'h12, 1, 0, 1'b0, '0);
    expect_latency(2, "bp_latency");
    e = exp_q[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("bp_hold_value", {result, flags}, e);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    op = 4'd2; a = 8'h05; b = 8'h20; c_in = 1'b1; dec = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("no_bubble_ready", in_ready, 1);
    push_exp(2, 'h05, 'h20, 1, 0, 1'b0, '0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_latency(2, "no_bubble_latency");
    drain("drain_bp");

    // Reset while in ADJ
    send(1, 'h27, 'h45, 0, 1, 1'b0, '0);
    @(posedge clk); #1;
    chk("adj_no_valid", out_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_result", result, 0);
    chk("rst_mid_flags", flags, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    exp_q.delete();
    m_res = 0;
    m_v = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk("no_stale_result", out_valid, 0);
    end

    // Randomized traffic with random backpressure
    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 1), $urandom_range(0, 1), 1'b0, '0);
    end
    bp_rand = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drain("drain_random");

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
